sdr_arbiter: RTL and testbench

SDR_ARBITER -- requirements
Module: sdr_arbiter

---
 rtl/sdr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single-request
//             SDRAM controller. One transaction outstanding at a time,
//             with a read-data timeout that completes with an error.
//  Revision : 1.0  initial release
// ============================================================================
module sdr_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    // requester 0
    input  logic        p0_valid,
    input  logic        p0_rw,
    input  logic [22:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    // requester 1
    input  logic        p1_valid,
    input  logic        p1_rw,
    input  logic [22:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    // SDRAM controller side
    output logic [22:0] user_addr,
    output logic        rw,
    output logic [31:0] data_in,
    output logic        in_valid,
    input  logic        busy,
    input  logic [31:0] data_out,
    input  logic        out_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        GUARD   = 3'd2,
        WAIT_RD = 3'd3,
        WAIT_WR = 3'd4
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    state_t      state;
    state_t      state_next;
    logic        last_q;      // port granted most recently
    logic        sel_q;       // port owning the current transaction
    logic [7:0]  cnt_q;       // cycles since the request entered GUARD

    logic        grant;       // latch a new request this cycle
    logic        winner;      // port selected by round-robin
    logic        done;        // transaction completes this cycle
    logic        done_rd;     // completion updates rdata
    logic        done_err;    // completion is a read timeout
    logic [8:0]  cnt_inc;
    logic        timed_out;

    assign in_valid  = (state == ISSUE);
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign timed_out = (cnt_inc >= {1'b0, TIMEOUT});

    // Next-state and completion decode.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        done_rd    = 1'b0;
        done_err   = 1'b0;
        winner     = (p0_valid && p1_valid) ? ~last_q : p1_valid;
        case (state)
            IDLE: begin
                // The cycle carrying an ack is spent idle so a requester
                // still holding valid is not mistaken for a new request.
                if ((p0_valid || p1_valid) && !(p0_ack || p1_ack)) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!busy) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                if (!rw && out_valid) begin
                    done       = 1'b1;
                    done_rd    = 1'b1;
                    state_next = IDLE;
                end else if (rw) begin
                    state_next = WAIT_WR;
                end else begin
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (out_valid) begin
                    done       = 1'b1;
                    done_rd    = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    done       = 1'b1;
                    done_rd    = 1'b1;
                    done_err   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_WR: begin
                if (!busy) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, timeout counter and per-port completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            cnt_q     <= 8'd0;
            user_addr <= 23'd0;
            rw        <= 1'b0;
            data_in   <= 32'd0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= 32'd0;
            p1_rdata  <= 32'd0;
        end else begin
            p0_ack <= done && !sel_q;
            p1_ack <= done &&  sel_q;
            p0_err <= done_err && !sel_q;
            p1_err <= done_err &&  sel_q;

            if (grant) begin
                user_addr <= winner ? p1_addr  : p0_addr;
                rw        <= winner ? p1_rw    : p0_rw;
                data_in   <= winner ? p1_wdata : p0_wdata;
                sel_q     <= winner;
                last_q    <= winner;
            end

            if (state == ISSUE && state_next == GUARD) begin
                cnt_q <= 8'd0;
            end else if (state == GUARD || state == WAIT_RD) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (done_rd && !sel_q) begin
                p0_rdata <= done_err ? ERR_DATA : data_out;
            end
            if (done_rd && sel_q) begin
                p1_rdata <= done_err ? ERR_DATA : data_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdr_arbiter
//  Purpose  : Directed self-checking bench for sdr_arbiter (TIMEOUT = 20).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 1'b0, p0_rw = 1'b0;
    logic [22:0] p0_addr = 23'd0;
    logic [31:0] p0_wdata = 32'd0;
    logic        p1_valid = 1'b0, p1_rw = 1'b0;
    logic [22:0] p1_addr = 23'd0;
    logic [31:0] p1_wdata = 32'd0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [22:0] user_addr;
    logic        rw, in_valid;
    logic [31:0] data_in;
    logic        busy = 1'b0;
    logic [31:0] data_out = 32'd0;
    logic        out_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    sdr_arbiter #(.TIMEOUT(8'd20)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .user_addr(user_addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
        .busy(busy), .data_out(data_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Tick until either ack is seen; returns the acked port (or -1).
    task automatic wait_any_ack(input int max, output int port);
        logic seen;
        seen = 1'b0;
        port = -1;
        for (int i = 0; i < max; i++) begin
            tick;
            if (p0_ack || p1_ack) begin
                seen = 1'b1;
                port = p1_ack ? 1 : 0;
                break;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        int port;
        int nv;
        int nack;

        // ---------------- reset values ----------------
        do_reset;
        check("rst_in_valid", 32'(in_valid), 32'd0);
        check("rst_p0_ack",   32'(p0_ack),   32'd0);
        check("rst_p1_err",   32'(p1_err),   32'd0);
        check("rst_p0_rdata", p0_rdata,      32'd0);
        check("rst_user_addr", 32'(user_addr), 32'd0);
        check("rst_data_in",  data_in,       32'd0);
        rst = 1'b0;
        tick;

        // ---------------- single read ----------------
        p0_valid = 1'b1; p0_rw = 1'b0; p0_addr = 23'h000010;
        tick;                                   // ISSUE
        check("rd_in_valid", 32'(in_valid), 32'd1);
        check("rd_user_addr", 32'(user_addr), 32'h10);
        check("rd_rw", 32'(rw), 32'd0);
        tick;                                   // accepted -> GUARD (cycle 1)
        check("rd_guard_in_valid", 32'(in_valid), 32'd0);
        tick;                                   // cycle 2
        tick;                                   // cycle 3
        tick;                                   // cycle 4
        out_valid = 1'b1; data_out = 32'h12345678;
        tick;
        out_valid = 1'b0;
        check("rd_p0_ack", 32'(p0_ack), 32'd1);
        check("rd_p0_rdata", p0_rdata, 32'h12345678);
        check("rd_p0_err", 32'(p0_err), 32'd0);
        check("rd_p1_ack", 32'(p1_ack), 32'd0);
        p0_valid = 1'b0;
        tick;
        check("rd_ack_one_cycle", 32'(p0_ack), 32'd0);
        check("rd_rdata_hold", p0_rdata, 32'h12345678);

        // ---------------- tie / round robin ----------------
        p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 23'h111; p0_wdata = 32'h1;
        p1_valid = 1'b1; p1_rw = 1'b1; p1_addr = 23'h222; p1_wdata = 32'h2;
        do_reset;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(20, port);
            check("rr_order", 32'(port), 32'(k % 2));
            check("rr_single_ack", 32'(p0_ack && p1_ack), 32'd0);
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick;
        check("rr_p1_rdata_untouched", p1_rdata, 32'd0);

        // ---------------- busy at issue ----------------
        p1_valid = 1'b1; p1_rw = 1'b0; p1_addr = 23'h5; busy = 1'b1;
        tick;                                   // ISSUE
        nv = 0;
        repeat (10) begin
            if (in_valid) nv++;
            tick;
        end
        busy = 1'b0;
        if (in_valid) nv++;
        tick;                                   // GUARD
        if (in_valid) nv++;
        check("busy_in_valid_cycles", 32'(nv), 32'd11);
        tick;                                   // WAIT_RD
        out_valid = 1'b1; data_out = 32'h0BADF00D;
        tick;
        out_valid = 1'b0;
        check("busy_p1_ack", 32'(p1_ack), 32'd1);
        check("busy_p1_rdata", p1_rdata, 32'h0BADF00D);
        p1_valid = 1'b0;
        nack = 0;
        repeat (8) begin
            tick;
            if (p0_ack || p1_ack || in_valid) nack++;
        end
        check("busy_no_extra", 32'(nack), 32'd0);

        // ---------------- cache hit in GUARD ----------------
        p0_valid = 1'b1; p0_rw = 1'b0; p0_addr = 23'h20;
        tick;                                   // ISSUE
        tick;                                   // GUARD
        out_valid = 1'b1; data_out = 32'hCAFEF00D;
        tick;
        out_valid = 1'b0;
        check("hit_p0_ack", 32'(p0_ack), 32'd1);
        check("hit_p0_rdata", p0_rdata, 32'hCAFEF00D);
        check("hit_p0_err", 32'(p0_err), 32'd0);
        p0_valid = 1'b0;
        tick;
        check("hit_ack_low", 32'(p0_ack), 32'd0);
        check("hit_idle", 32'(in_valid), 32'd0);

        // ---------------- write ----------------
        p1_valid = 1'b1; p1_rw = 1'b1; p1_addr = 23'h7FFFFF; p1_wdata = 32'hA5A5A5A5;
        tick;                                   // ISSUE
        check("wr_in_valid", 32'(in_valid), 32'd1);
        check("wr_user_addr", 32'(user_addr), 32'h7FFFFF);
        check("wr_data_in", data_in, 32'hA5A5A5A5);
        check("wr_rw", 32'(rw), 32'd1);
        tick;                                   // GUARD
        busy = 1'b1;
        out_valid = 1'b1; data_out = 32'hFFFFFFFF;
        nack = 0;
        repeat (3) begin
            tick;
            if (p1_ack) nack++;
        end
        check("wr_no_ack_while_busy", 32'(nack), 32'd0);
        busy = 1'b0; out_valid = 1'b0;
        tick;
        check("wr_p1_ack", 32'(p1_ack), 32'd1);
        check("wr_p1_err", 32'(p1_err), 32'd0);
        check("wr_p1_rdata_kept", p1_rdata, 32'h0BADF00D);
        p1_valid = 1'b0;
        tick;

        // ---------------- read timeout ----------------
        p0_valid = 1'b1; p0_rw = 1'b0; p0_addr = 23'h30;
        tick;                                   // ISSUE
        tick;                                   // GUARD
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            nv++;
            if (p0_ack) break;
        end
        check("to_latency", 32'(nv), 32'd20);
        check("to_p0_ack", 32'(p0_ack), 32'd1);
        check("to_p0_err", 32'(p0_err), 32'd1);
        check("to_p0_rdata", p0_rdata, 32'hDEADBEEF);
        p0_valid = 1'b0;
        p1_valid = 1'b1; p1_rw = 1'b0; p1_addr = 23'h40;
        tick;                                   // IDLE (ack cycle done)
        tick;                                   // ISSUE
        tick;                                   // GUARD
        out_valid = 1'b1; data_out = 32'h11112222;
        tick;
        out_valid = 1'b0;
        check("post_to_p1_ack", 32'(p1_ack), 32'd1);
        check("post_to_p1_err", 32'(p1_err), 32'd0);
        check("post_to_p1_rdata", p1_rdata, 32'h11112222);
        check("post_to_p0_err", 32'(p0_err), 32'd0);
        p1_valid = 1'b0;
        tick;

        // ---------------- reset mid-transaction ----------------
        p0_valid = 1'b1; p0_rw = 1'b0; p0_addr = 23'h50;
        tick;                                   // ISSUE
        tick;                                   // GUARD
        tick;                                   // WAIT_RD
        rst = 1'b1;
        tick;
        rst = 1'b0; p0_valid = 1'b0;
        check("abort_in_valid", 32'(in_valid), 32'd0);
        check("abort_p0_rdata", p0_rdata, 32'd0);
        out_valid = 1'b1; data_out = 32'h77777777;
        tick;
        out_valid = 1'b0;
        nack = 0;
        repeat (5) begin
            if (p0_ack || p1_ack) nack++;
            tick;
        end
        check("abort_no_ack", 32'(nack), 32'd0);
        check("abort_rdata_ignored", p0_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
